// File: rtl/trap_reporter.sv
// Commit-stage trap reporter: counts cycles/instructions, captures the trap, drains, then reports.
// Optional no-commit watchdog enabled by defining TRAP_REPORTER_WATCHDOG_EN.
module trap_reporter #(
    parameter int COMMIT_WIDTH   = 2,
    parameter int DRAIN_CYCLES   = 4,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [COMMIT_WIDTH-1:0]    commit_valid,
    input  logic [COMMIT_WIDTH-1:0]    commit_is_trap,
    input  logic [COMMIT_WIDTH*32-1:0] commit_pc,
    input  logic [31:0]                trap_code_in,
    input  logic                       trap_ack,
    output logic                       is_noop_trap,
    output logic [31:0]                trap_code,
    output logic [31:0]                trap_pc,
    output logic [31:0]                cycle_cnt,
    output logic [31:0]                instr_cnt,
    output logic                       busy
);

    // state    | meaning
    // S_RUN    | counting cycles and commits, watching for the trap
    // S_DRAIN  | trap captured, waiting for the pipeline to settle
    // S_REPORT | report valid and frozen until trap_ack
    typedef enum logic [1:0] {S_RUN, S_DRAIN, S_REPORT} state_t;

    localparam int DW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

    if (COMMIT_WIDTH < 1 || COMMIT_WIDTH > 8 || TIMEOUT_CYCLES < 1) begin : g_bad_params
    end

    state_t          state_q, state_d;
    logic [31:0]     cycle_q, cycle_d;
    logic [31:0]     instr_q, instr_d;
    logic [31:0]     code_q, code_d;
    logic [31:0]     pc_q, pc_d;
    logic [DW-1:0]   drain_q, drain_d;

    logic            trap_found;
    logic [31:0]     trap_slot_pc;
    logic [31:0]     commit_num;
    logic            capture_en;
    logic [31:0]     capture_code;
    logic [31:0]     capture_pc;

    // Only slots up to and including the lowest valid trap slot are counted.
    always_comb begin
        trap_found   = 1'b0;
        trap_slot_pc = '0;
        commit_num   = '0;
        for (int i = 0; i < COMMIT_WIDTH; i++) begin
            if (!trap_found) begin
                if (commit_valid[i]) commit_num = commit_num + 32'd1;
                if (commit_valid[i] && commit_is_trap[i]) begin
                    trap_found   = 1'b1;
                    trap_slot_pc = commit_pc[32*i +: 32];
                end
            end
        end
    end

`ifdef TRAP_REPORTER_WATCHDOG_EN
    localparam int WW = $clog2(TIMEOUT_CYCLES + 1);
    logic [WW-1:0] wd_q, wd_d;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) wd_q <= '0;
        else        wd_q <= wd_d;
    end
`endif

    always_comb begin
        state_d      = state_q;
        cycle_d      = cycle_q;
        instr_d      = instr_q;
        code_d       = code_q;
        pc_d         = pc_q;
        drain_d      = drain_q;
        capture_en   = 1'b0;
        capture_code = trap_code_in;
        capture_pc   = trap_slot_pc;
`ifdef TRAP_REPORTER_WATCHDOG_EN
        wd_d         = '0;
`endif
        case (state_q)
            S_RUN: begin
                cycle_d = cycle_q + 32'd1;
                instr_d = instr_q + commit_num;
                if (trap_found) begin
                    capture_en = 1'b1;
                end
`ifdef TRAP_REPORTER_WATCHDOG_EN
                else if (commit_valid == '0) begin
                    if (wd_q == WW'(TIMEOUT_CYCLES - 1)) begin
                        capture_en   = 1'b1;
                        capture_code = 32'hFFFF_FFFE;
                        capture_pc   = commit_pc[31:0];
                    end else begin
                        wd_d = wd_q + 1'b1;
                    end
                end
`endif
                if (capture_en) begin
                    code_d = capture_code;
                    pc_d   = capture_pc;
                    if (DRAIN_CYCLES == 0) begin
                        state_d = S_REPORT;
                    end else begin
                        state_d = S_DRAIN;
                        drain_d = DW'(DRAIN_CYCLES - 1);
                    end
                end
            end
            S_DRAIN: begin
                cycle_d = cycle_q + 32'd1;
                if (drain_q == '0) state_d = S_REPORT;
                else               drain_d = drain_q - 1'b1;
            end
            S_REPORT: begin
                if (trap_ack) begin
                    state_d = S_RUN;
                    cycle_d = '0;
                    instr_d = '0;
                    code_d  = '0;
                    pc_d    = '0;
                    drain_d = '0;
                end
            end
            default: state_d = S_RUN;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_RUN;
            cycle_q <= '0;
            instr_q <= '0;
            code_q  <= '0;
            pc_q    <= '0;
            drain_q <= '0;
        end else begin
            state_q <= state_d;
            cycle_q <= cycle_d;
            instr_q <= instr_d;
            code_q  <= code_d;
            pc_q    <= pc_d;
            drain_q <= drain_d;
        end
    end

    assign is_noop_trap = (state_q == S_REPORT);
    assign busy         = (state_q != S_RUN);
    assign trap_code    = code_q;
    assign trap_pc      = pc_q;
    assign cycle_cnt    = cycle_q;
    assign instr_cnt    = instr_q;

endmodule

// File: doc/trap_reporter.md
Name: trap_reporter

Overview:
- Producer side of the simulation trap/monitor interface.
- Sits at the core's commit stage. Counts cycles and committed instructions, detects commit of the trap instruction, and captures the trap code and PC.
- Drives a stable trap report (is_noop_trap, trap_code, trap_pc, cycle_cnt, instr_cnt) to the monitor sink.
- A drain phase holds off the report until the pipeline has settled.

Parameters:
- COMMIT_WIDTH, 2, number of commit slots per cycle (1..8).
- DRAIN_CYCLES, 4, cycles between trap commit and report assertion (0 = assert on the next cycle).
- TIMEOUT_CYCLES, 4096, no-commit window for the optional watchdog.

Ports:
- clk  input  1  core clock.
- reset  input  1  asynchronous, active-low reset.
- commit_valid  input  COMMIT_WIDTH  slot i committed this cycle.
- commit_is_trap  input  COMMIT_WIDTH  slot i is the trap instruction; ignored unless commit_valid[i].
- commit_pc  input  COMMIT_WIDTH*32  PC of slot i in bits [32i+31:32i].
- trap_code_in  input  32  architectural a0 value, valid in any cycle with a valid trap slot.
- trap_ack  input  1  sink has consumed the report; rearms the block.
- is_noop_trap  output  1  trap report valid.
- trap_code  output  32  captured trap code.
- trap_pc  output  32  captured trap PC.
- cycle_cnt  output  32  cycles since reset or rearm.
- instr_cnt  output  32  instructions committed since reset or rearm.
- busy  output  1  high in DRAIN or REPORT.

Behaviour:
- Reset (reset low, asynchronous):
  - state=RUN.
  - All outputs 0, including cycle_cnt and instr_cnt.
  - Drain counter 0; watchdog counter 0.
- States:
  - RUN:
    - cycle_cnt += 1 each cycle.
    - instr_cnt += popcount of counted slots. Counted slots = valid slots at or below the lowest-index valid trap slot t, or all valid slots if no trap.
    - Commit gaps (non-contiguous valid bits) are legal; count every valid bit in range.
    - On a valid trap at slot t: latch trap_pc=commit_pc[t] and trap_code=trap_code_in. Go to DRAIN, or to REPORT if DRAIN_CYCLES=0.
    - Slots above t are ignored: not counted, no capture.
  - DRAIN:
    - cycle_cnt keeps incrementing; instr_cnt frozen.
    - Any commit_valid is ignored and never recaptures.
    - After DRAIN_CYCLES cycles in DRAIN, go to REPORT.
  - REPORT:
    - is_noop_trap=1. trap_code, trap_pc, cycle_cnt, instr_cnt all frozen and stable.
    - On trap_ack=1: go to RUN next cycle. Zero cycle_cnt, instr_cnt, trap_code, trap_pc; clear is_noop_trap.
- trap_ack outside REPORT has no effect.
- Output timing: is_noop_trap rises DRAIN_CYCLES+1 cycles after the cycle in which the trap committed.
- Arithmetic: 32-bit counters wrap modulo 2^32 with no saturation and no flag.
- Reset asserted mid-DRAIN or mid-REPORT: immediate return to the reset state; no partial report stays visible.
- Registered outputs only: no combinational path from inputs to outputs.

Optional Feature:
- Macro: TRAP_REPORTER_WATCHDOG_EN.
- With the macro defined:
  - In RUN, a watchdog counter increments on each cycle with no valid commit and clears on any valid commit.
  - When it reaches TIMEOUT_CYCLES, capture trap_code=32'hFFFF_FFFE and trap_pc=commit_pc[0] as sampled that cycle, then go to DRAIN. instr_cnt is unchanged.
  - The watchdog counter clears on entry to RUN.
- Without the macro: no watchdog logic is present, and a hung core never produces a report.

Test Plan:
- Reset low for 3 cycles, then release with no commits for 10 cycles: all outputs 0 during reset, then cycle_cnt=10, instr_cnt=0, is_noop_trap=0.
- COMMIT_WIDTH=2; commit_valid=2'b11 for 5 cycles, then a trap in slot 0 with pc 0x8000_0100 and code 0: report has instr_cnt=11, trap_pc=0x8000_0100, trap_code=0. is_noop_trap rises exactly 5 cycles after the trap cycle.
- Trap in slot 1 and slot 0 non-trap, same cycle, with pc1=0x8000_0204 and code 1: slot 0 counted, trap_pc=0x8000_0204, trap_code=1. A second trap in slot 0 during DRAIN with pc 0x9000_0000 leaves the capture unchanged.
- Wrap: force instr_cnt to 0xFFFF_FFFF, then commit 2 instructions: instr_cnt=1.
- In REPORT, pulse trap_ack: next cycle is_noop_trap=0 and all counters 0. Asserting reset in the 2nd DRAIN cycle immediately zeroes all outputs.
- With TRAP_REPORTER_WATCHDOG_EN and TIMEOUT_CYCLES=16: 16 idle cycles in RUN give trap_code=0xFFFF_FFFE after DRAIN_CYCLES+1 further cycles.
